fan_speed_pwm: RTL and testbench



---
 rtl/fan_pkg.sv | 14 +
 rtl/pwm_gen.sv | 29 ++
 rtl/fan_speed_pwm.sv | 58 +++++
 tb/tb_fan_speed_pwm.sv | 111 +++++++++++
 4 files changed

// File: rtl/fan_pkg.sv
// fan_pkg: shared one-hot fan speed encoding and default duty levels.
package fan_pkg;
    localparam logic [3:0] ST_STOP = 4'b0001;
    localparam logic [3:0] ST_LOW  = 4'b0010;
    localparam logic [3:0] ST_MID  = 4'b0100;
    localparam logic [3:0] ST_HIGH = 4'b1000;
    localparam int DUTY_LOW_DEF  = 64;
    localparam int DUTY_MID_DEF  = 128;
    localparam int DUTY_HIGH_DEF = 230;
    // STOP->LOW->MID->HIGH->STOP is a rotate-left of the one-hot code
    function automatic logic [3:0] next_speed(input logic [3:0] s);
        return {s[2:0], s[3]};
    endfunction
endpackage

// File: rtl/pwm_gen.sv
// pwm_gen: prescaled free-running PWM counter with registered duty compare.
module pwm_gen #(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 4
) (
    input  logic                clk,
    input  logic                reset_p,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm,
    output logic                period_boundary
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    logic [PW-1:0]       pre;
    logic [PWM_BITS-1:0] cnt;
    logic                tick;
    assign tick = pre == PW'(PRESCALE - 1);
    assign period_boundary = tick && (cnt == '1);
    always_ff @(posedge clk) begin
        if (reset_p) begin
            pre <= '0;
            cnt <= '0;
            pwm <= 1'b0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            cnt <= tick ? cnt + 1'b1 : cnt;
            pwm <= duty > cnt;
        end
    end
endmodule

// File: rtl/fan_speed_pwm.sv
// fan_speed_pwm: button-stepped fan speed FSM driving a PWM motor output.
// Define FAN_SOFT_START_EN to ramp duty by RAMP_STEP per PWM period.
module fan_speed_pwm
    import fan_pkg::*;
#(
    parameter int PWM_BITS  = 8,
    parameter int PRESCALE  = 4,
    parameter int DUTY_LOW  = DUTY_LOW_DEF,
    parameter int DUTY_MID  = DUTY_MID_DEF,
    parameter int DUTY_HIGH = DUTY_HIGH_DEF,
    parameter int RAMP_STEP = 4
) (
    input  logic                clk,
    input  logic                reset_p,
    input  logic                btn_pedge,
    input  logic                timeout_pedge,
    output logic [3:0]          speed_state,
    output logic                fan_en,
    output logic [PWM_BITS-1:0] duty,
    output logic                pwm
);
`ifdef FAN_SOFT_START_EN
    localparam logic SOFT = 1'b1;
`else
    localparam logic SOFT = 1'b0;
`endif
    localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(RAMP_STEP);
    logic [3:0]          nxt_state;
    logic [PWM_BITS-1:0] target, diff, new_duty;
    logic                up, boundary;
    always_comb begin
        nxt_state = timeout_pedge ? ST_STOP : btn_pedge ? next_speed(speed_state) : speed_state;
        target = speed_state == ST_HIGH ? PWM_BITS'(DUTY_HIGH) :
                 speed_state == ST_MID  ? PWM_BITS'(DUTY_MID)  :
                 speed_state == ST_LOW  ? PWM_BITS'(DUTY_LOW)  : '0;
        up = target > duty;
        diff = up ? target - duty : duty - target;
        new_duty = (!SOFT || diff <= STEP) ? target : up ? duty + STEP : duty - STEP;
    end
    always_ff @(posedge clk) begin
        if (reset_p) begin
            speed_state <= ST_STOP;
            fan_en      <= 1'b0;
            duty        <= '0;
        end else begin
            speed_state <= nxt_state;
            fan_en      <= nxt_state != ST_STOP;
            duty        <= boundary ? new_duty : duty;
        end
    end
    pwm_gen #(.PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE)) u_pwm (
        .clk             (clk),
        .reset_p         (reset_p),
        .duty            (duty),
        .pwm             (pwm),
        .period_boundary (boundary)
    );
endmodule

// File: tb/tb_fan_speed_pwm.sv
// tb_fan_speed_pwm: directed plus random stimulus against a period-level fan model.
module tb_fan_speed_pwm;
    logic       clk = 1'b0;
    logic       reset_p = 1'b1;
    logic       btn_pedge = 1'b0;
    logic       timeout_pedge = 1'b0;
    logic [3:0] speed_state;
    logic       fan_en;
    logic [7:0] duty;
    logic       pwm;
    int tests = 0, fails = 0;
    int lvl = 0, mduty = 0, k = 0, mpwm = 0, hi = 0;
    int tgt [4] = '{0, 64, 128, 230};

    fan_speed_pwm #(.PWM_BITS(8), .PRESCALE(1), .DUTY_LOW(64), .DUTY_MID(128),
                    .DUTY_HIGH(230), .RAMP_STEP(4)) dut (
        .clk           (clk),
        .reset_p       (reset_p),
        .btn_pedge     (btn_pedge),
        .timeout_pedge (timeout_pedge),
        .speed_state   (speed_state),
        .fan_en        (fan_en),
        .duty          (duty),
        .pwm           (pwm)
    );

    always #5 clk = ~clk;

    function automatic int ramp(int d, int t);
`ifdef FAN_SOFT_START_EN
        if (t > d) return (t - d <= 4) ? t : d + 4;
        return (d - t <= 4) ? t : d - 4;
`else
        return t;
`endif
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, k);
        end
    endtask

    task automatic check_all();
        chk("speed_state", 32'(speed_state), 32'(1 << lvl));
        chk("fan_en", 32'(fan_en), 32'(lvl != 0));
        chk("duty", 32'(duty), 32'(mduty));
        chk("pwm", 32'(pwm), 32'(mpwm));
    endtask

    // one clock: position in the 256-clk period before the edge decides pwm and boundary
    task automatic cyc(input bit b, input bit t);
        int pos;
        btn_pedge = b;
        timeout_pedge = t;
        @(posedge clk);
        #1;
        pos = k % 256;
        mpwm = (mduty > pos) ? 1 : 0;
        if (pos == 255) mduty = ramp(mduty, tgt[lvl]);
        lvl = t ? 0 : b ? (lvl + 1) % 4 : lvl;
        k++;
        btn_pedge = 1'b0;
        timeout_pedge = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        reset_p = 1'b1;
        @(posedge clk);
        #1;
        lvl = 0; mduty = 0; k = 0; mpwm = 0;
        reset_p = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0);
    endtask

    initial begin
        do_reset();
        idle(3);
        cyc(1, 0);
        idle(17 * 256 - (k % 256));
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            cyc(0, 0);
            hi += int'(pwm);
        end
        chk("pwm_high_count_low", 32'(hi), 32'd64);
        cyc(1, 0); idle(300);
        cyc(1, 0); idle(300);
        cyc(1, 0); idle(300);
        cyc(1, 0); idle(300);
        cyc(1, 0); idle(300);
        cyc(1, 1); idle(600);
        cyc(0, 1); idle(300);
        cyc(1, 0); cyc(1, 0);
        idle(9 * 256);
        while (k % 256 != 100) cyc(0, 0);
        do_reset();
        idle(300);
        for (int i = 0; i < 6000; i++)
            cyc($urandom_range(0, 149) == 0, $urandom_range(0, 399) == 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
